// File: rtl/rom_bus_sequencer.sv
// rom_bus_sequencer: arbitrates SNES ROM-path accesses against MCU memory
// requests and runs timed read/write cycles on the external 16-bit SRAM0 bus.
// SNES always wins arbitration; every bus cycle is followed by a one-cycle
// turnaround gap with all strobes released.
module rom_bus_sequencer #(
  parameter int RD_CYCLES = 4,
  parameter int WR_CYCLES = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SNES_RD_STB,
  input  logic        SNES_WR_STB,
  input  logic [23:0] ROM_ADDR,
  input  logic        ROM_HIT,
  input  logic        IS_WRITABLE,
  input  logic [7:0]  SNES_DIN,
  output logic [7:0]  SNES_DOUT,
  output logic        SNES_DOUT_VLD,
  input  logic        MCU_RRQ,
  input  logic        MCU_WRQ,
  input  logic [23:0] MCU_ADDR,
  input  logic [7:0]  MCU_DIN,
  output logic [7:0]  MCU_DOUT,
  output logic        MCU_RDY,
  output logic [22:0] MEM_ADDR,
  output logic [15:0] MEM_DQ_OUT,
  output logic        MEM_DQ_OE,
  input  logic [15:0] MEM_DQ_IN,
  output logic        MEM_OE_n,
  output logic        MEM_WE_n,
  output logic        MEM_BLE_n,
  output logic        MEM_BHE_n
);

  typedef enum logic [2:0] {IDLE, SRD, SWR, MRD, MWR, GAP} state_t;

  localparam int CNT_W = 8;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             byte_sel;

  // single SNES slot (newest strobe wins) and single MCU slot
  logic             snes_pend;
  logic             snes_wr;
  logic [23:0]      snes_addr;
  logic [7:0]       snes_data;
  logic             mcu_pend;
  logic             mcu_wr;
  logic [23:0]      mcu_addr;
  logic [7:0]       mcu_data;

  logic             snes_rd_ok;
  logic             snes_wr_ok;
  logic             snes_new;
  logic             mcu_new;
  logic             start;
  logic             start_wr;
  logic             start_mcu;
  logic [23:0]      start_addr;
  logic [7:0]       start_data;
  logic [7:0]       rd_byte;

  // Misses and non-writable writes never reach the pending slot
  assign snes_rd_ok = SNES_RD_STB & ROM_HIT;
  assign snes_wr_ok = SNES_WR_STB & ROM_HIT & IS_WRITABLE;
  assign snes_new   = snes_rd_ok | snes_wr_ok;
  assign mcu_new    = (MCU_RRQ | MCU_WRQ) & MCU_RDY;
  assign rd_byte    = byte_sel ? MEM_DQ_IN[15:8] : MEM_DQ_IN[7:0];

  // Choose what IDLE launches: a same-cycle strobe bypasses its slot, SNES beats MCU
  always_comb begin
    start      = 1'b0;
    start_wr   = 1'b0;
    start_mcu  = 1'b0;
    start_addr = '0;
    start_data = '0;
    if (snes_new) begin
      start      = 1'b1;
      start_wr   = snes_wr_ok;
      start_addr = ROM_ADDR;
      start_data = SNES_DIN;
    end else if (snes_pend) begin
      start      = 1'b1;
      start_wr   = snes_wr;
      start_addr = snes_addr;
      start_data = snes_data;
    end else if (mcu_new) begin
      start      = 1'b1;
      start_mcu  = 1'b1;
      start_wr   = MCU_WRQ;
      start_addr = MCU_ADDR;
      start_data = MCU_DIN;
    end else if (mcu_pend) begin
      start      = 1'b1;
      start_mcu  = 1'b1;
      start_wr   = mcu_wr;
      start_addr = mcu_addr;
      start_data = mcu_data;
    end
  end

  // Request capture, arbitration and bus cycle sequencing with registered strobes
  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      cnt           <= '0;
      byte_sel      <= 1'b0;
      snes_pend     <= 1'b0;
      snes_wr       <= 1'b0;
      snes_addr     <= '0;
      snes_data     <= '0;
      mcu_pend      <= 1'b0;
      mcu_wr        <= 1'b0;
      mcu_addr      <= '0;
      mcu_data      <= '0;
      MEM_ADDR      <= '0;
      MEM_DQ_OUT    <= '0;
      MEM_DQ_OE     <= 1'b0;
      MEM_OE_n      <= 1'b1;
      MEM_WE_n      <= 1'b1;
      MEM_BLE_n     <= 1'b1;
      MEM_BHE_n     <= 1'b1;
      SNES_DOUT     <= '0;
      SNES_DOUT_VLD <= 1'b0;
      MCU_DOUT      <= '0;
      MCU_RDY       <= 1'b1;
    end else begin
      SNES_DOUT_VLD <= 1'b0;

      if (snes_new) begin
        snes_pend <= 1'b1;
        snes_wr   <= snes_wr_ok;
        snes_addr <= ROM_ADDR;
        snes_data <= SNES_DIN;
      end
      if (mcu_new) begin
        mcu_pend <= 1'b1;
        mcu_wr   <= MCU_WRQ;
        mcu_addr <= MCU_ADDR;
        mcu_data <= MCU_DIN;
        MCU_RDY  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            // the launched request leaves its slot (later assignment wins)
            if (start_mcu) mcu_pend <= 1'b0;
            else           snes_pend <= 1'b0;
            MEM_ADDR  <= start_addr[23:1];
            byte_sel  <= start_addr[0];
            MEM_BLE_n <= start_addr[0];
            MEM_BHE_n <= ~start_addr[0];
            if (start_wr) begin
              MEM_WE_n   <= 1'b0;
              MEM_DQ_OE  <= 1'b1;
              MEM_DQ_OUT <= {start_data, start_data};
              cnt        <= CNT_W'(WR_CYCLES - 1);
            end else begin
              MEM_OE_n <= 1'b0;
              cnt      <= CNT_W'(RD_CYCLES - 1);
            end
            state <= start_mcu ? (start_wr ? MWR : MRD) : (start_wr ? SWR : SRD);
          end
        end
        SRD, MRD: begin
          if (cnt == '0) begin
            MEM_OE_n  <= 1'b1;
            MEM_BLE_n <= 1'b1;
            MEM_BHE_n <= 1'b1;
            state     <= GAP;
            if (state == SRD) begin
              SNES_DOUT     <= rd_byte;
              SNES_DOUT_VLD <= 1'b1;
            end else begin
              MCU_DOUT <= rd_byte;
              MCU_RDY  <= 1'b1;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        SWR, MWR: begin
          if (cnt == '0) begin
            // data keeps driving through GAP so it stays valid past WE_n rising
            MEM_WE_n  <= 1'b1;
            MEM_BLE_n <= 1'b1;
            MEM_BHE_n <= 1'b1;
            state     <= GAP;
            if (state == MWR) MCU_RDY <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        GAP: begin
          MEM_DQ_OE <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_bus_sequencer.sv
// tb_rom_bus_sequencer: directed plus randomized checks of rom_bus_sequencer
// against a byte-addressed memory reference and an ordered list of expected
// bus cycles; a negedge monitor turns the raw bus into cycle records.
module tb_rom_bus_sequencer;

  localparam int RD = 4;
  localparam int WR = 3;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        SNES_RD_STB = 1'b0;
  logic        SNES_WR_STB = 1'b0;
  logic [23:0] ROM_ADDR = '0;
  logic        ROM_HIT = 1'b0;
  logic        IS_WRITABLE = 1'b0;
  logic [7:0]  SNES_DIN = '0;
  logic [7:0]  SNES_DOUT;
  logic        SNES_DOUT_VLD;
  logic        MCU_RRQ = 1'b0;
  logic        MCU_WRQ = 1'b0;
  logic [23:0] MCU_ADDR = '0;
  logic [7:0]  MCU_DIN = '0;
  logic [7:0]  MCU_DOUT;
  logic        MCU_RDY;
  logic [22:0] MEM_ADDR;
  logic [15:0] MEM_DQ_OUT;
  logic        MEM_DQ_OE;
  logic [15:0] MEM_DQ_IN = 16'hDEAD;
  logic        MEM_OE_n;
  logic        MEM_WE_n;
  logic        MEM_BLE_n;
  logic        MEM_BHE_n;

  rom_bus_sequencer #(.RD_CYCLES(RD), .WR_CYCLES(WR)) dut (
    .CLK(CLK), .RST(RST),
    .SNES_RD_STB(SNES_RD_STB), .SNES_WR_STB(SNES_WR_STB), .ROM_ADDR(ROM_ADDR),
    .ROM_HIT(ROM_HIT), .IS_WRITABLE(IS_WRITABLE), .SNES_DIN(SNES_DIN),
    .SNES_DOUT(SNES_DOUT), .SNES_DOUT_VLD(SNES_DOUT_VLD),
    .MCU_RRQ(MCU_RRQ), .MCU_WRQ(MCU_WRQ), .MCU_ADDR(MCU_ADDR), .MCU_DIN(MCU_DIN),
    .MCU_DOUT(MCU_DOUT), .MCU_RDY(MCU_RDY),
    .MEM_ADDR(MEM_ADDR), .MEM_DQ_OUT(MEM_DQ_OUT), .MEM_DQ_OE(MEM_DQ_OE),
    .MEM_DQ_IN(MEM_DQ_IN), .MEM_OE_n(MEM_OE_n), .MEM_WE_n(MEM_WE_n),
    .MEM_BLE_n(MEM_BLE_n), .MEM_BHE_n(MEM_BHE_n)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // one observed or expected bus cycle
  typedef struct {
    bit          wr;
    logic [22:0] addr;
    logic        ble;
    logic        bhe;
    int          len;
    int          dqlen;
    logic [15:0] dq;
    bit          stable;
    int          gap;
    int          start_cyc;
    int          end_cyc;
  } bus_cyc_t;

  bus_cyc_t obs_q[$];
  bus_cyc_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // SRAM contents: words never written read as a fixed address hash
  logic [15:0] sram [int];
  logic [7:0]  ref_mem [int];
  logic [7:0]  exp_sdout = '0;
  logic [7:0]  exp_mdout = '0;
  int          exp_vld = 0;

  function automatic logic [15:0] init_word(input logic [22:0] w);
    return {w[7:0] ^ 8'h5C, w[15:8] + w[7:0] + 8'h31};
  endfunction

  function automatic logic [15:0] sram_rd(input logic [22:0] w);
    if (sram.exists(int'(w))) return sram[int'(w)];
    return init_word(w);
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] dq,
                                        input logic ble_n, input logic bhe_n);
    logic [15:0] r;
    r = old;
    if (!ble_n) r[7:0] = dq[7:0];
    if (!bhe_n) r[15:8] = dq[15:8];
    return r;
  endfunction

  // reference: plain byte memory
  function automatic logic [7:0] ref_byte(input logic [23:0] a);
    logic [15:0] w;
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    w = init_word(a[23:1]);
    return a[0] ? w[15:8] : w[7:0];
  endfunction

  // bus monitor and SRAM model, evaluated mid-cycle
  int oe_len = 0, we_len = 0, dq_len = 0, idle_run = 1000;
  int vld_cnt = 0, vld_run = 0, vld_max = 0, rdy_rise_cyc = -1;
  logic prev_rdy = 1'b1;
  bus_cyc_t rcur, wcur;

  initial forever begin
    @(negedge CLK);
    if (!MEM_WE_n && MEM_DQ_OE)
      sram[int'(MEM_ADDR)] = merge(sram_rd(MEM_ADDR), MEM_DQ_OUT, MEM_BLE_n, MEM_BHE_n);
    MEM_DQ_IN = MEM_OE_n ? 16'hDEAD : sram_rd(MEM_ADDR);

    if (!MEM_OE_n) begin
      if (oe_len == 0) begin
        rcur = '{default: 0};
        rcur.addr = MEM_ADDR; rcur.ble = MEM_BLE_n; rcur.bhe = MEM_BHE_n;
        rcur.gap = idle_run; rcur.start_cyc = cyc; rcur.stable = 1'b1;
      end
      oe_len++;
    end else if (oe_len != 0) begin
      rcur.len = oe_len; rcur.end_cyc = cyc;
      obs_q.push_back(rcur);
      oe_len = 0;
    end

    if (!MEM_WE_n) begin
      if (we_len == 0) begin
        wcur = '{default: 0};
        wcur.wr = 1'b1; wcur.addr = MEM_ADDR; wcur.ble = MEM_BLE_n; wcur.bhe = MEM_BHE_n;
        wcur.gap = idle_run; wcur.start_cyc = cyc;
      end
      we_len++;
    end else if (we_len != 0) begin
      wcur.len = we_len; wcur.end_cyc = cyc;
      we_len = 0;
    end
    if (MEM_DQ_OE) begin
      if (dq_len == 0) begin
        wcur.dq = MEM_DQ_OUT; wcur.stable = 1'b1;
      end else if (MEM_DQ_OUT !== wcur.dq) begin
        wcur.stable = 1'b0;
      end
      dq_len++;
    end else if (dq_len != 0) begin
      wcur.dqlen = dq_len;
      obs_q.push_back(wcur);
      dq_len = 0;
    end

    if (MEM_OE_n && MEM_WE_n) idle_run++;
    else idle_run = 0;

    if (SNES_DOUT_VLD) begin
      vld_cnt++; vld_run++;
      if (vld_run > vld_max) vld_max = vld_run;
    end else begin
      vld_run = 0;
    end
    if (MCU_RDY && !prev_rdy) rdy_rise_cyc = cyc;
    prev_rdy = MCU_RDY;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic issue(input bit srd, input bit swr, input logic [23:0] ra, input bit hit,
                       input bit wrt, input logic [7:0] sd, input bit mrd, input bit mwr,
                       input logic [23:0] ma, input logic [7:0] md);
    SNES_RD_STB = srd; SNES_WR_STB = swr; ROM_ADDR = ra; ROM_HIT = hit;
    IS_WRITABLE = wrt; SNES_DIN = sd;
    MCU_RRQ = mrd; MCU_WRQ = mwr; MCU_ADDR = ma; MCU_DIN = md;
    @(posedge CLK);
    #1;
    SNES_RD_STB = 1'b0; SNES_WR_STB = 1'b0; MCU_RRQ = 1'b0; MCU_WRQ = 1'b0;
  endtask

  task automatic model_snes(input bit wr, input logic [23:0] a, input bit hit,
                            input bit wrt, input logic [7:0] d);
    bus_cyc_t e;
    e = '{default: 0};
    e.addr = a[23:1]; e.ble = a[0]; e.bhe = ~a[0];
    if (!wr && hit) begin
      e.len = RD;
      exp_q.push_back(e);
      exp_sdout = ref_byte(a);
      exp_vld++;
    end else if (wr && hit && wrt) begin
      e.wr = 1'b1; e.len = WR; e.dqlen = WR + 1; e.dq = {d, d};
      exp_q.push_back(e);
      ref_mem[int'(a)] = d;
    end
  endtask

  task automatic model_mcu(input bit wr, input logic [23:0] a, input logic [7:0] d);
    bus_cyc_t e;
    e = '{default: 0};
    e.addr = a[23:1]; e.ble = a[0]; e.bhe = ~a[0];
    if (!wr) begin
      e.len = RD;
      exp_q.push_back(e);
      exp_mdout = ref_byte(a);
    end else begin
      e.wr = 1'b1; e.len = WR; e.dqlen = WR + 1; e.dq = {d, d};
      exp_q.push_back(e);
      ref_mem[int'(a)] = d;
    end
  endtask

  task automatic drain(input string tag);
    int n;
    $display("txn %s: %0d bus cycles seen, %0d expected", tag, obs_q.size(), exp_q.size());
    chk({tag, " cycle count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, " kind"}, obs_q[i].wr, exp_q[i].wr);
      chk({tag, " addr"}, obs_q[i].addr, exp_q[i].addr);
      chk({tag, " ble_n"}, obs_q[i].ble, exp_q[i].ble);
      chk({tag, " bhe_n"}, obs_q[i].bhe, exp_q[i].bhe);
      chk({tag, " strobe len"}, obs_q[i].len, exp_q[i].len);
      chk({tag, " dq_oe len"}, obs_q[i].dqlen, exp_q[i].dqlen);
      chk({tag, " dq"}, obs_q[i].dq, exp_q[i].dq);
      if (exp_q[i].wr) chk({tag, " dq stable"}, obs_q[i].stable, 1);
      chk({tag, " turnaround"}, obs_q[i].gap >= 1, 1);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, " snes_dout"}, SNES_DOUT, exp_sdout);
    chk({tag, " mcu_dout"}, MCU_DOUT, exp_mdout);
    chk({tag, " vld count"}, vld_cnt, exp_vld);
    chk({tag, " mcu_rdy"}, MCU_RDY, 1);
  endtask

  initial begin
    int t0;
    // reset state
    RST = 1'b1;
    idle(3);
    chk("rst oe_n", MEM_OE_n, 1);
    chk("rst we_n", MEM_WE_n, 1);
    chk("rst ble_n", MEM_BLE_n, 1);
    chk("rst bhe_n", MEM_BHE_n, 1);
    chk("rst dq_oe", MEM_DQ_OE, 0);
    chk("rst mem_addr", MEM_ADDR, 0);
    chk("rst snes_dout", SNES_DOUT, 0);
    chk("rst mcu_dout", MCU_DOUT, 0);
    chk("rst vld", SNES_DOUT_VLD, 0);
    chk("rst mcu_rdy", MCU_RDY, 1);
    RST = 1'b0;
    idle(2);

    // SNES read of the high byte of a known word, latency 1 CLK
    sram[int'(23'h0091A2)] = 16'hAB12;
    ref_mem[int'(24'h012344)] = 8'h12;
    ref_mem[int'(24'h012345)] = 8'hAB;
    t0 = cyc;
    model_snes(0, 24'h012345, 1, 0, 8'h00);
    issue(1, 0, 24'h012345, 1, 0, 8'h00, 0, 0, 24'h0, 8'h00);
    idle(20);
    if (obs_q.size() > 0) chk("sread latency", obs_q[0].start_cyc, t0 + 1);
    drain("sread");
    chk("sread dout AB", SNES_DOUT, 8'hAB);
    chk_outs("sread");

    // SNES write, then a non-writable write to the same byte, then read back
    model_snes(1, 24'hE00010, 1, 1, 8'h5A);
    issue(0, 1, 24'hE00010, 1, 1, 8'h5A, 0, 0, 24'h0, 8'h00);
    idle(20);
    drain("swrite");
    model_snes(1, 24'hE00010, 1, 0, 8'h77);
    issue(0, 1, 24'hE00010, 1, 0, 8'h77, 0, 0, 24'h0, 8'h00);
    idle(20);
    drain("swrite ro");
    model_snes(0, 24'hE00010, 1, 0, 8'h00);
    issue(1, 0, 24'hE00010, 1, 0, 8'h00, 0, 0, 24'h0, 8'h00);
    idle(20);
    drain("readback");
    chk("readback 5A", SNES_DOUT, 8'h5A);
    chk_outs("readback");

    // MCU read, SNES read one CLK later: MCU first, RDY rises in its GAP
    model_mcu(0, 24'h003001, 8'h00);
    model_snes(0, 24'h003004, 1, 0, 8'h00);
    issue(0, 0, 24'h0, 0, 0, 8'h00, 1, 0, 24'h003001, 8'h00);
    chk("mcu rdy drops", MCU_RDY, 0);
    issue(1, 0, 24'h003004, 1, 0, 8'h00, 0, 0, 24'h0, 8'h00);
    idle(25);
    if (obs_q.size() > 0) chk("rdy rise in gap", rdy_rise_cyc, obs_q[0].end_cyc);
    drain("mcu then snes");
    chk_outs("mcu then snes");

    // same-cycle SNES write and MCU read of that byte: SNES goes first
    model_snes(1, 24'h003010, 1, 1, 8'h3C);
    model_mcu(0, 24'h003010, 8'h00);
    issue(0, 1, 24'h003010, 1, 1, 8'h3C, 1, 0, 24'h003010, 8'h00);
    idle(25);
    drain("same cycle");
    chk("same cycle mcu 3C", MCU_DOUT, 8'h3C);
    chk_outs("same cycle");

    // SNES miss produces nothing; MCU write while busy is ignored
    issue(1, 0, 24'h003008, 0, 0, 8'h00, 0, 0, 24'h0, 8'h00);
    idle(20);
    drain("snes miss");
    model_mcu(0, 24'h003020, 8'h00);
    issue(0, 0, 24'h0, 0, 0, 8'h00, 1, 0, 24'h003020, 8'h00);
    issue(0, 0, 24'h0, 0, 0, 8'h00, 0, 1, 24'h003021, 8'hEE);
    idle(25);
    drain("mcu busy wrq");
    model_mcu(0, 24'h003021, 8'h00);
    issue(0, 0, 24'h0, 0, 0, 8'h00, 1, 0, 24'h003021, 8'h00);
    idle(20);
    drain("mcu busy check");
    chk_outs("mcu busy");

    // reset on the second WE_n-low cycle, with an MCU read waiting behind it
    issue(0, 1, 24'hE00020, 1, 1, 8'h99, 1, 0, 24'h003000, 8'h00);
    idle(1);
    chk("rst mid we before", MEM_WE_n, 0);
    chk("rst mid rdy before", MCU_RDY, 0);
    RST = 1'b1;
    idle(1);
    chk("rst mid we_n", MEM_WE_n, 1);
    chk("rst mid dq_oe", MEM_DQ_OE, 0);
    chk("rst mid oe_n", MEM_OE_n, 1);
    chk("rst mid mcu_rdy", MCU_RDY, 1);
    RST = 1'b0;
    exp_sdout = '0;
    exp_mdout = '0;
    idle(20);
    $display("txn reset mid write: %0d bus cycles seen", obs_q.size());
    chk("rst mid cycles", obs_q.size(), 1);
    if (obs_q.size() > 0) chk("rst mid we len", obs_q[0].len, 2);
    obs_q.delete();
    exp_q.delete();
    chk_outs("rst mid");

    // randomized traffic in a small window so reads see earlier writes
    for (int it = 0; it < 40; it++) begin
      int          kind;
      logic [23:0] sa, ma;
      logic [7:0]  sd, md;
      bit          hit, wrt, swr, mwr;
      kind = $urandom_range(0, 4);
      sa   = 24'h003000 + 24'($urandom_range(0, 15));
      ma   = 24'h003000 + 24'($urandom_range(0, 15));
      sd   = 8'($urandom);
      md   = 8'($urandom);
      hit  = ($urandom_range(0, 3) != 0);
      wrt  = 1'($urandom_range(0, 1));
      swr  = 1'($urandom_range(0, 1));
      mwr  = 1'($urandom_range(0, 1));
      case (kind)
        0: begin
          model_snes(0, sa, hit, wrt, sd);
          issue(1, 0, sa, hit, wrt, sd, 0, 0, ma, md);
        end
        1: begin
          model_snes(1, sa, hit, wrt, sd);
          issue(0, 1, sa, hit, wrt, sd, 0, 0, ma, md);
        end
        2: begin
          model_mcu(0, ma, md);
          issue(0, 0, sa, hit, wrt, sd, 1, 0, ma, md);
        end
        3: begin
          model_mcu(1, ma, md);
          issue(0, 0, sa, hit, wrt, sd, 0, 1, ma, md);
        end
        default: begin
          model_snes(swr, sa, hit, wrt, sd);
          model_mcu(mwr, ma, md);
          issue(!swr, swr, sa, hit, wrt, sd, !mwr, mwr, ma, md);
        end
      endcase
      idle(25);
      drain($sformatf("rand%0d kind%0d", it, kind));
      chk_outs($sformatf("rand%0d", it));
    end

    chk("vld width", vld_max, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
